stage3_flatten_buffer: RTL and testbench
========================================

# stage3_flatten_buffer

Sink for the stage-3 max-pool output stream. On each valid pulse it captures one wide vector of `CH` pooled channel values. After `N_PIX` vectors it re-emits the whole pooled feature map one element per beat in channel-major flatten order (c, then pixel). Output is a valid/ready stream toward the fully-connected layer. The block decouples the pooling pipeline, which cannot be stalled, from a back-pressured FC consumer.

## Interface
Parameters:
- `CH`, 3: channels per pooled vector (matches `pool_CO`).
- `BW`, 32: bits per element (matches `ST3_OF_BW`), signed two's complement.
- `N_PIX`, 16: pooled pixels per frame.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `i_pool_valid`, in, 1: one-cycle strobe marking a valid pooled vector.
- `i_pool_data`, in, CH*BW: channel c is at bits [c*BW +: BW].
- `o_valid`, out, 1: flattened element available.
- `i_ready`, in, 1: consumer accepts the element when `o_valid && i_ready`.
- `o_data`, out, BW: current flattened element.
- `o_last`, out, 1: high with the final element of the frame.
- `o_busy`, out, 1: high while in DRAIN.
- `o_overflow`, out, 1: sticky; set when an input vector is dropped.

## Operation
- Storage: CH*N_PIX registers of BW bits, addressed as `mem[c][p]`.
- FSM has two states, FILL and DRAIN. The reset state is FILL.
- FILL:
  - On `i_pool_valid`, write `mem[c][wr_pix] <= i_pool_data[c*BW +: BW]` for all c, then increment `wr_pix`.
  - On the capture with `wr_pix == N_PIX-1`, clear `wr_pix` to 0, clear `rd_ch`/`rd_pix` to 0, and go to DRAIN.
- DRAIN:
  - `o_data = mem[rd_ch][rd_pix]`.
  - On each handshake, increment `rd_pix`. When `rd_pix` wraps from N_PIX-1 to 0, increment `rd_ch`.
  - The handshake with `rd_ch == CH-1 && rd_pix == N_PIX-1` returns the FSM to FILL.
- Emission order: index k = c*N_PIX + p, for k = 0 to CH*N_PIX-1.
- `i_pool_valid` during DRAIN: the vector is dropped, memory is not written, and `o_overflow` is set. `o_overflow` is cleared only by reset.
- Data passes through unmodified: no arithmetic, no sign change.
- `o_data`, `o_last`, `o_valid` and `o_busy` are decoded from registered state and the memory. There is no combinational path from `i_pool_valid`/`i_pool_data` to any output.
- `o_last = o_valid && rd_ch == CH-1 && rd_pix == N_PIX-1`.

## Timing
- Reset values:
  - `o_valid`, `o_last`, `o_busy`, `o_overflow` are 0.
  - `o_data` is 0, because all memory resets to 0.
  - FSM is in FILL; all counters are 0.
- Reset mid-frame (in FILL or DRAIN): the partial frame is discarded and the block restarts in FILL with counters at 0.
- Fill-to-drain latency: `o_valid` rises in the cycle after the edge that captures the N_PIX-th vector, with element k=0 on `o_data`.
- With `i_ready` held at 1, one element is emitted per cycle, so a drain takes CH*N_PIX cycles.
- Handshake rules:
  - `o_valid` stays high and `o_data` stays stable until the element is accepted.
  - `i_ready` may toggle freely.
  - `i_ready` while `o_valid == 0` has no effect.
- Back-to-back frames: a capture is accepted in the first cycle the FSM is in FILL, which is the cycle after the last handshake.
- A capture arriving on the same edge as the last handshake is dropped, because the FSM is still in DRAIN on that edge, and `o_overflow` is set.

## Structure
- `BW`, `CH` and `N_PIX` defaults come from the shared CNN defines header (`ST3_OF_BW`, `pool_CO`, pooled map size).
- The FSM state encoding lives as localparams in the same header.
- One sub-module is natural: `stage3_flatten_mux`, a combinational CH*N_PIX-to-1 element select indexed by `{rd_ch, rd_pix}`.
- Counter widths are `$clog2(N_PIX)` and `$clog2(CH)`, each with a minimum of 1.

## Test plan
- **Basic frame:** defaults, `i_ready` held 1. Drive 16 pulses with channel c of pixel p = c*100+p.
  - `o_valid` rises one cycle after the 16th pulse.
  - 48 beats are emitted, with values 0..15, 100..115, 200..215.
  - `o_last` is high only on the value 215.
- **Back-pressure:** same frame, with `i_ready` toggling in a 1,0,0,1 pattern.
  - `o_data` is held stable while `i_ready` is 0.
  - Identical sequence to the basic frame; no beats lost or duplicated.
- **Overflow:** pulse `i_pool_valid` with data 0xDEAD at every lane during DRAIN.
  - `o_overflow` goes to 1 and stays 1.
  - The drained values are unchanged and 0xDEAD never appears on `o_data`.
- **Signed pass-through:** inputs 0x80000000 and 0xFFFFFFFF appear bit-exact on `o_data`.
- **Reset mid-drain:** assert `reset_n` low after beat 20.
  - All outputs go to 0 and the FSM is in FILL.
  - A new 16-pulse frame drains from k=0.
- **Boundary edge:** issue an input pulse on the same edge as the final handshake.
  - That vector is dropped and `o_overflow` is set.
  - A pulse one cycle later is captured as pixel 0.

Source files
------------

// File: rtl/stage3_flatten_buffer_pkg.sv
// ---------------------------------------------------------------------------
// stage3_flatten_buffer_pkg : shared CNN stage-3 defaults and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stage3_flatten_buffer_pkg;

  localparam int ST3_OF_BW    = 32;
  localparam int POOL_CO      = 3;
  localparam int ST3_POOL_PIX = 16;

  localparam logic [0:0] ST_FILL_ENC  = 1'b0;
  localparam logic [0:0] ST_DRAIN_ENC = 1'b1;

  typedef enum logic [0:0] {
    ST_FILL  = ST_FILL_ENC,
    ST_DRAIN = ST_DRAIN_ENC
  } state_t;

  // Counter width with a floor of one bit so degenerate sizes still elaborate.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage3_flatten_mux.sv
// ---------------------------------------------------------------------------
// stage3_flatten_mux : combinational CH*N_PIX-to-1 element select
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stage3_flatten_mux
  import stage3_flatten_buffer_pkg::*;
#(
  parameter int CH    = POOL_CO,
  parameter int BW    = ST3_OF_BW,
  parameter int N_PIX = ST3_POOL_PIX,
  parameter int CW    = cnt_w(CH),
  parameter int PW    = cnt_w(N_PIX)
) (
  input  logic [CH-1:0][N_PIX-1:0][BW-1:0] mem,
  input  logic [CW-1:0]                    rd_ch,
  input  logic [PW-1:0]                    rd_pix,
  output logic [BW-1:0]                    data
);

  always_comb begin
    data = '0;
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < N_PIX; p++) begin
        if (rd_ch == CW'(c) && rd_pix == PW'(p)) begin
          data = mem[c][p];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage3_flatten_buffer.sv
// ---------------------------------------------------------------------------
// stage3_flatten_buffer : captures N_PIX pooled vectors, re-emits channel-major
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stage3_flatten_buffer
  import stage3_flatten_buffer_pkg::*;
#(
  parameter int CH    = POOL_CO,
  parameter int BW    = ST3_OF_BW,
  parameter int N_PIX = ST3_POOL_PIX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_pool_valid,
  input  logic [CH*BW-1:0] i_pool_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BW-1:0]    o_data,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int CW = cnt_w(CH);
  localparam int PW = cnt_w(N_PIX);

  state_t                          state;
  logic [CW-1:0]                   rd_ch;
  logic [PW-1:0]                   rd_pix;
  logic [PW-1:0]                   wr_pix;
  logic                            overflow;
  logic [CH-1:0][N_PIX-1:0][BW-1:0] mem;

  logic capture;
  logic rd_pix_end;
  logic rd_ch_end;

  assign capture    = i_pool_valid && (state == ST_FILL);
  assign rd_pix_end = (rd_pix == PW'(N_PIX - 1));
  assign rd_ch_end  = (rd_ch == CW'(CH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        for (int p = 0; p < N_PIX; p++) begin
          if (capture && wr_pix == PW'(p)) begin
            mem[c][p] <= i_pool_data[c*BW +: BW];
          end
        end
      end
    end
  end

  // A vector arriving in DRAIN (including the final-handshake edge) is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FILL;
      wr_pix   <= '0;
      rd_ch    <= '0;
      rd_pix   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (i_pool_valid) begin
            if (wr_pix == PW'(N_PIX - 1)) begin
              wr_pix <= '0;
              rd_ch  <= '0;
              rd_pix <= '0;
              state  <= ST_DRAIN;
            end else begin
              wr_pix <= wr_pix + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (i_pool_valid) begin
            overflow <= 1'b1;
          end
          if (i_ready) begin
            if (rd_pix_end) begin
              rd_pix <= '0;
              if (rd_ch_end) begin
                rd_ch <= '0;
                state <= ST_FILL;
              end else begin
                rd_ch <= rd_ch + 1'b1;
              end
            end else begin
              rd_pix <= rd_pix + 1'b1;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  stage3_flatten_mux #(
    .CH    (CH),
    .BW    (BW),
    .N_PIX (N_PIX),
    .CW    (CW),
    .PW    (PW)
  ) u_mux (
    .mem    (mem),
    .rd_ch  (rd_ch),
    .rd_pix (rd_pix),
    .data   (o_data)
  );

  assign o_valid    = (state == ST_DRAIN);
  assign o_busy     = (state == ST_DRAIN);
  assign o_last     = o_valid && rd_ch_end && rd_pix_end;
  assign o_overflow = overflow;

endmodule

`default_nettype wire

// File: tb/tb_stage3_flatten_buffer.sv
// ---------------------------------------------------------------------------
// tb_stage3_flatten_buffer : scoreboard bench for the stage-3 flatten buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stage3_flatten_buffer;

  localparam int CH    = 3;
  localparam int BW    = 32;
  localparam int N_PIX = 16;
  localparam int TOTAL = CH * N_PIX;
  localparam int LIMIT = 400;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pool_valid = 1'b0;
  logic [CH*BW-1:0] pool_data = '0;
  logic             ready = 1'b0;
  logic             o_valid;
  logic [BW-1:0]    o_data;
  logic             o_last;
  logic             o_busy;
  logic             o_overflow;

  logic [BW-1:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage3_flatten_buffer #(.CH(CH), .BW(BW), .N_PIX(N_PIX)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_pool_valid (pool_valid),
    .i_pool_data  (pool_data),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  function automatic logic [BW-1:0] val(input int kind, input int c, input int p);
    case (kind)
      0:       return BW'(c * 100 + p);
      1:       return (((c + p) % 2) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return BW'(5000 + c * 100 + p);
    endcase
  endfunction

  // Drives pixels first_pix..N_PIX-1 and queues the whole frame in flatten order.
  task automatic fill_frame(input int kind, input int first_pix);
    for (int p = first_pix; p < N_PIX; p++) begin
      @(negedge clk);
      pool_valid = 1'b1;
      for (int c = 0; c < CH; c++) pool_data[c*BW +: BW] = val(kind, c, p);
      if (p == N_PIX - 1) begin
        n_cmp++;
        if (o_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL early_valid: o_valid=%b required 0 before last capture", o_valid);
        end
      end
    end
    @(negedge clk);
    pool_valid = 1'b0;
    pool_data  = '0;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < N_PIX; p++) q.push_back(val(kind, c, p));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_valid, o_last, o_busy, o_overflow} !== 4'b0 || o_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state: v/l/b/o=%b%b%b%b data=%h required 0000 data 0",
               o_valid, o_last, o_busy, o_overflow, o_data);
    end
    reset_n = 1'b1;
    ready   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== '0) begin
      n_bad++;
      $display("FAIL post_reset: o_valid=%b o_data=%h required 0/0", o_valid, o_data);
    end
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1, 2: drop pulses during drain, 3: pulse on final edge
  task automatic test_frame(input string name, input int kind, input int mode, input int first_pix);
    int beats = 0;
    int cyc = 0;
    fill_frame(kind, first_pix);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== val(kind, 0, 0)) begin
      n_bad++;
      $display("FAIL %s latency: o_valid=%b o_data=%h required 1/%h", name, o_valid, o_data, val(kind, 0, 0));
    end
    while (beats < TOTAL && cyc < LIMIT) begin
      ready = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (o_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s extra_beat: o_data=%h with empty scoreboard", name, o_data);
        end else begin
          n_cmp++;
          if (o_data !== q[0]) begin
            n_bad++;
            $display("FAIL %s data k=%0d: o_data=%h required %h", name, beats, o_data, q[0]);
          end
          n_cmp++;
          if (o_last !== (q.size() == 1)) begin
            n_bad++;
            $display("FAIL %s last k=%0d: o_last=%b required %b", name, beats, o_last, q.size() == 1);
          end
          n_cmp++;
          if (o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy k=%0d: o_busy=%b required 1", name, beats, o_busy);
          end
          if (mode == 3) begin
            pool_valid = ready && (q.size() == 1);
            pool_data  = {CH{32'h0000_DEAD}};
          end
          if (ready) begin
            void'(q.pop_front());
            beats++;
          end
        end
      end
      if (mode == 2) begin
        pool_valid = ((cyc % 2) == 1);
        pool_data  = {CH{32'h0000_DEAD}};
      end
      @(negedge clk);
      cyc++;
    end
    if (beats < TOTAL) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: %0d beats, required %0d", name, beats, TOTAL);
    end
    if (mode == 3) begin
      pool_valid = 1'b1;
      for (int c = 0; c < CH; c++) pool_data[c*BW +: BW] = val(2, c, 0);
    end else begin
      pool_valid = 1'b0;
      pool_data  = '0;
    end
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s end_valid: o_valid=%b required 0 after final beat", name, o_valid);
    end
    if (mode == 2 || mode == 3) begin
      n_cmp++;
      if (o_overflow !== 1'b1) begin
        n_bad++;
        $display("FAIL %s overflow: o_overflow=%b required 1", name, o_overflow);
      end
    end
    if (mode == 2) begin
      repeat (5) @(negedge clk);
      n_cmp++;
      if (o_overflow !== 1'b1) begin
        n_bad++;
        $display("FAIL %s overflow_sticky: o_overflow=%b required 1", name, o_overflow);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    fill_frame(0, 0);
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (o_data !== q[0]) begin
        n_bad++;
        $display("FAIL mid_drain data k=%0d: o_data=%h required %h", i, o_data, q[0]);
      end
      void'(q.pop_front());
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_last, o_busy, o_overflow} !== 4'b0 || o_data !== '0) begin
      n_bad++;
      $display("FAIL mid_drain reset: v/l/b/o=%b%b%b%b data=%h required 0000 data 0",
               o_valid, o_last, o_busy, o_overflow, o_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_drain fill_state: o_valid=%b required 0", o_valid);
    end
    test_frame("post_rst", 0, 0, 0);
  endtask

  task automatic test_boundary();
    n_cmp++;
    if (o_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL edge pre_overflow: o_overflow=%b required 0", o_overflow);
    end
    test_frame("edge", 0, 3, 0);
    test_frame("edge_next", 2, 0, 1);
  endtask

  initial begin
    test_reset();
    test_frame("basic", 0, 0, 0);
    test_frame("backpressure", 0, 1, 0);
    test_frame("signed", 1, 0, 0);
    test_reset_mid_drain();
    test_boundary();
    test_frame("overflow", 0, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
